uvme_axis_st_sink: RTL and testbench

//  Synthesizable AXI-Stream slave (receiving end) for the uvme_axis_st self-test env.
//  - Accepts beats on the s_ port, applying programmable LFSR back-pressure on tready.
//  - Buffers beats in an internal FIFO; the bench drains them through a first-word-fall-through pop port.
//  - Counts beats and packets.

---
 rtl/uvme_axis_st_sink_pkg.sv | 18 +
 rtl/uvme_axis_st_sink_fifo.sv | 51 +++++
 rtl/uvme_axis_st_sink.sv | 188 ++++++++++++++++++
 tb/tb_uvme_axis_st_sink.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uvme_axis_st_sink_pkg.sv
// Shared types and helpers for the uvme_axis_st_sink AXI-Stream receiver.
// Provides the packet-framing state type, counter/LFSR widths and the LFSR step.
package uvme_axis_st_sink_pkg;

    localparam int LFSR_W = 16;
    localparam int CNT_W  = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } uvme_axis_st_sink_st_e;

    // Fibonacci LFSR, taps 16,14,13,11 counted from the shifted-out end (bit 0).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/uvme_axis_st_sink_fifo.sv
// Beat storage for uvme_axis_st_sink: synchronous write, first-word-fall-through read.
// The caller only pushes when a slot is free and only pops when not empty.
module uvme_axis_st_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/uvme_axis_st_sink.sv
// AXI-Stream sink: LFSR-throttled registered tready, FWFT beat FIFO, beat/packet counters.
// Define UVME_AXIS_ST_SINK_PROTO_CHK_EN to build the stalled-beat protocol checker.
module uvme_axis_st_sink
    import uvme_axis_st_sink_pkg::*;
#(
    parameter int              DATA_W     = 64,
    parameter int              FIFO_DEPTH = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic                cfg_thr_en,
    input  logic [7:0]          cfg_thr_pct,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic [DATA_W/8-1:0] rd_keep,
    output logic                rd_last,
    output logic                rd_empty,
    output logic [CNT_W-1:0]    beat_cnt,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic                err_underrun,
    output logic [1:0]          proto_err
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] OCC_ONE   = (CW+1)'(1);
    localparam logic [CW:0] OCC_LIMIT = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    beat_t                 wr_beat;
    beat_t                 head_beat;
    beat_t                 rd_beat;
    logic                  s_tready_q;
    logic                  handshake;
    logic                  fifo_push;
    logic                  pop_ok;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           count_next;
    logic [LFSR_W-1:0]     lfsr;
    logic                  throttle_ok;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [CNT_W-1:0]      pkt_cnt_q;
    logic                  underrun_q;
    logic                  pkt_end;
    uvme_axis_st_sink_st_e state;
    uvme_axis_st_sink_st_e state_next;

    assign wr_beat   = '{data: s_tdata, keep: s_tkeep, last: s_tlast};
    assign handshake = s_tvalid && s_tready_q;
    assign fifo_push = handshake && (!fifo_full || pop_ok);
    assign pop_ok    = rd_en && !fifo_empty;

    uvme_axis_st_sink_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop_ok),
        .wdata (wr_beat),
        .rdata (head_beat),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Occupancy after this edge; ready is granted only if a further beat would still fit.
    always_comb begin
        count_next = {1'b0, fifo_count};
        if (fifo_push) begin
            count_next = count_next + OCC_ONE;
        end
        if (pop_ok) begin
            count_next = count_next - OCC_ONE;
        end
    end

    assign throttle_ok = !cfg_thr_en || (lfsr[7:0] < cfg_thr_pct);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            s_tready_q <= 1'b0;
        end else begin
            lfsr       <= lfsr_next(lfsr);
            s_tready_q <= (count_next < OCC_LIMIT) && throttle_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (handshake) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if (pkt_end) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
            if (rd_en && fifo_empty) begin
                underrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A single-beat packet (tlast on the first beat) never leaves IDLE.
    always_comb begin
        state_next = state;
        if (handshake) begin
            case (state)
                IDLE:   if (!s_tlast) state_next = IN_PKT;
                IN_PKT: if (s_tlast)  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_end = 1'b0;
        if (handshake && s_tlast) begin
            pkt_end = 1'b1;
        end
    end

`ifdef UVME_AXIS_ST_SINK_PROTO_CHK_EN
    logic       stall_q;
    beat_t      stall_beat_q;
    logic [1:0] proto_err_q;

    // Compare this cycle's payload against the beat that was left waiting last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q      <= 1'b0;
            stall_beat_q <= '0;
            proto_err_q  <= 2'b00;
        end else begin
            stall_q <= s_tvalid && !s_tready_q;
            if (s_tvalid && !s_tready_q) begin
                stall_beat_q <= wr_beat;
            end
            if (stall_q && !s_tvalid) begin
                proto_err_q[0] <= 1'b1;
            end
            if (stall_q && s_tvalid && (wr_beat != stall_beat_q)) begin
                proto_err_q[1] <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 2'b00;
`endif

    assign rd_beat      = fifo_empty ? '0 : head_beat;
    assign rd_data      = rd_beat.data;
    assign rd_keep      = rd_beat.keep;
    assign rd_last      = rd_beat.last;
    assign rd_empty     = fifo_empty;
    assign s_tready     = s_tready_q;
    assign beat_cnt     = beat_cnt_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign err_underrun = underrun_q;

endmodule

// File: tb/tb_uvme_axis_st_sink.sv
// Self-checking bench for uvme_axis_st_sink: directed vector table, hand-written corner
// sequences, and randomized traffic scored against a queue-based FIFO model.
module tb_uvme_axis_st_sink;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DEPTH  = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata = '0;
    logic [KEEP_W-1:0] s_tkeep = '0;
    logic              s_tlast = 1'b0;
    logic              cfg_thr_en = 1'b0;
    logic [7:0]        cfg_thr_pct = 8'd0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic [KEEP_W-1:0] rd_keep;
    logic              rd_last;
    logic              rd_empty;
    logic [31:0]       beat_cnt;
    logic [31:0]       pkt_cnt;
    logic              err_underrun;
    logic [1:0]        proto_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } bb_t;

    typedef struct {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              rd;
        logic              exp_ready;
        logic              exp_empty;
        int                exp_beats;
        int                exp_pkts;
        logic [DATA_W-1:0] exp_data;
        logic              exp_last;
    } vec_t;

    bb_t  q[$];
    bb_t  cur;
    vec_t vecs[8];

    uvme_axis_st_sink #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .cfg_thr_en   (cfg_thr_en),
        .cfg_thr_pct  (cfg_thr_pct),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_keep      (rd_keep),
        .rd_last      (rd_last),
        .rd_empty     (rd_empty),
        .beat_cnt     (beat_cnt),
        .pkt_cnt      (pkt_cnt),
        .err_underrun (err_underrun),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] m);
        return {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    endfunction

    // Holds reset for a few cycles, releases it on a falling edge, then idles one cycle.
    task automatic do_reset(input logic en, input logic [7:0] pct);
        reset       = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = 1'b0;
        rd_en       = 1'b0;
        cfg_thr_en  = en;
        cfg_thr_pct = pct;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic new_beat();
        cur.data = {$urandom, $urandom};
        cur.keep = KEEP_W'($urandom);
        cur.last = ($urandom_range(0, 3) == 0);
        s_tdata  = cur.data;
        s_tkeep  = cur.keep;
        s_tlast  = cur.last;
    endtask

    task automatic pop_compare(input string tag);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_extra: got beat %0h, want no beat", tag, rd_data);
        end else begin
            check_output({tag, "_data"}, rd_data, q[0].data);
            check_output({tag, "_keep"}, rd_keep, q[0].keep);
            check_output({tag, "_last"}, rd_last, q[0].last);
            void'(q.pop_front());
        end
    endtask

    initial begin
        int   acc;
        int   sent;
        int   cycles;
        int   pkts;
        logic hs;
        logic prev_hs;
        logic exp_und;
        logic [15:0] m;

        vecs[0] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 64'h0,  1'b0};
        vecs[1] = '{1'b1, 64'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 64'hA1, 1'b0};
        vecs[2] = '{1'b1, 64'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 64'hA1, 1'b0};
        vecs[3] = '{1'b1, 64'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 64'hA1, 1'b0};
        vecs[4] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b0, 3, 1, 64'hB2, 1'b0};
        vecs[5] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b0, 3, 1, 64'hC3, 1'b1};
        vecs[6] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 1'b1, 3, 1, 64'h0,  1'b0};
        vecs[7] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1'b1, 3, 1, 64'h0,  1'b0};

        // Reset state while reset is still held.
        repeat (2) @(negedge clk);
        check_output("rst_ready", s_tready, 1'b0);
        check_output("rst_empty", rd_empty, 1'b1);
        check_output("rst_beats", beat_cnt, 0);
        check_output("rst_pkts", pkt_cnt, 0);
        check_output("rst_rd_data", rd_data, 0);
        check_output("rst_rd_last", rd_last, 1'b0);
        check_output("rst_underrun", err_underrun, 1'b0);
        check_output("rst_proto", proto_err, 2'b00);

        // Three-beat packet through the vector table, then drained in order.
        do_reset(1'b0, 8'd0);
        s_tkeep = '1;
        for (int i = 0; i < 8; i++) begin
            s_tvalid = vecs[i].valid;
            s_tdata  = vecs[i].data;
            s_tlast  = vecs[i].last;
            rd_en    = vecs[i].rd;
            @(negedge clk);
            check_output($sformatf("vec%0d_ready", i), s_tready, vecs[i].exp_ready);
            check_output($sformatf("vec%0d_empty", i), rd_empty, vecs[i].exp_empty);
            check_output($sformatf("vec%0d_beats", i), beat_cnt, vecs[i].exp_beats);
            check_output($sformatf("vec%0d_pkts", i), pkt_cnt, vecs[i].exp_pkts);
            check_output($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            check_output($sformatf("vec%0d_last", i), rd_last, vecs[i].exp_last);
            check_output($sformatf("vec%0d_underrun", i), err_underrun, 1'b0);
        end

        // Fill: 16 accepted with no pops, then one pop admits exactly one more.
        do_reset(1'b0, 8'd0);
        s_tkeep = '1;
        acc = 0;
        for (int i = 0; i < 25; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'(acc);
            hs = s_tready;
            @(negedge clk);
            if (hs) acc++;
        end
        check_output("fill_accepts", acc, 16);
        check_output("fill_ready", s_tready, 1'b0);
        check_output("fill_beats", beat_cnt, 16);
        check_output("fill_head", rd_data, 0);
        rd_en = 1'b1;
        hs = s_tready;
        @(negedge clk);
        if (hs) acc++;
        rd_en = 1'b0;
        check_output("fill_pop_ready", s_tready, 1'b1);
        check_output("fill_pop_head", rd_data, 1);
        for (int i = 0; i < 5; i++) begin
            s_tdata = DATA_W'(acc);
            hs = s_tready;
            @(negedge clk);
            if (hs) acc++;
        end
        s_tvalid = 1'b0;
        check_output("fill_accepts_after_pop", acc, 17);
        check_output("fill_beats_after_pop", beat_cnt, 17);
        check_output("fill_ready_after_pop", s_tready, 1'b0);

        // Underrun on empty, then push and rd_en together on an empty FIFO.
        do_reset(1'b0, 8'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_output("und_flag", err_underrun, 1'b1);
        check_output("und_empty", rd_empty, 1'b1);
        repeat (3) @(negedge clk);
        check_output("und_sticky", err_underrun, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 64'h55;
        s_tkeep  = 8'h0F;
        s_tlast  = 1'b1;
        rd_en    = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        rd_en    = 1'b0;
        check_output("und_push_empty", rd_empty, 1'b0);
        check_output("und_push_data", rd_data, 64'h55);
        check_output("und_push_keep", rd_keep, 8'h0F);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_output("und_pop_empty", rd_empty, 1'b1);
        check_output("und_pop_sticky", err_underrun, 1'b1);

        // Stalled beat changes payload, then valid drops while still stalled.
        do_reset(1'b1, 8'd0);
        s_tvalid = 1'b1;
        s_tdata  = 64'h11;
        s_tkeep  = '1;
        s_tlast  = 1'b0;
        @(negedge clk);
        check_output("proto_stall_ready", s_tready, 1'b0);
        s_tdata = 64'h22;
        @(negedge clk);
`ifdef UVME_AXIS_ST_SINK_PROTO_CHK_EN
        check_output("proto_payload", proto_err, 2'b10);
`else
        check_output("proto_payload", proto_err, 2'b00);
`endif
        s_tvalid = 1'b0;
        @(negedge clk);
`ifdef UVME_AXIS_ST_SINK_PROTO_CHK_EN
        check_output("proto_drop", proto_err, 2'b11);
`else
        check_output("proto_drop", proto_err, 2'b00);
`endif
        check_output("proto_beats", beat_cnt, 0);

        // Reset asserted mid-packet after beat 2 of 4.
        do_reset(1'b0, 8'd0);
        s_tkeep = '1;
        for (int i = 1; i <= 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DATA_W'(i);
            s_tlast  = 1'b0;
            @(negedge clk);
        end
        check_output("midrst_beats_before", beat_cnt, 2);
        s_tdata = 64'h3;
        #2 reset = 1'b1;
        #1;
        check_output("midrst_ready", s_tready, 1'b0);
        check_output("midrst_beats", beat_cnt, 0);
        check_output("midrst_pkts", pkt_cnt, 0);
        check_output("midrst_empty", rd_empty, 1'b1);
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 64'h77;
        s_tlast  = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        check_output("midrst_single_pkts", pkt_cnt, 1);
        check_output("midrst_single_beats", beat_cnt, 1);
        check_output("midrst_single_data", rd_data, 64'h77);
        check_output("midrst_single_last", rd_last, 1'b1);

        // Throttle-only ready pattern against the LFSR sequence from the seed.
        do_reset(1'b1, 8'd160);
        m = SEED;
        for (int k = 0; k < 48; k++) begin
            check_output($sformatf("lfsr_ready%0d", k), s_tready, (m[7:0] < 8'd160));
            m = lfsr_step(m);
            @(negedge clk);
        end

        // 1000 continuous beats at 50% throttle, popping whenever data is present.
        do_reset(1'b1, 8'd128);
        sent = 0;
        cycles = 0;
        pkts = 0;
        s_tvalid = 1'b1;
        new_beat();
        while (sent < 1000 && cycles < 5000) begin
            rd_en = !rd_empty;
            if (rd_en) pop_compare("thr");
            hs = s_tready;
            @(negedge clk);
            cycles++;
            if (hs) begin
                q.push_back(cur);
                sent++;
                if (cur.last) pkts++;
                new_beat();
            end
        end
        s_tvalid = 1'b0;
        check_output("thr_sent", sent, 1000);
        check_output("thr_beats", beat_cnt, 1000);
        check_output("thr_pkts", pkt_cnt, pkts);
        check_output("thr_ratio_in_40_60pct", (cycles >= 1667) && (cycles <= 2500), 1'b1);
        for (int k = 0; k < 4; k++) begin
            rd_en = !rd_empty;
            if (rd_en) pop_compare("thr_drain");
            @(negedge clk);
        end
        rd_en = 1'b0;
        check_output("thr_drained_model", q.size(), 0);
        check_output("thr_drained_empty", rd_empty, 1'b1);

        // Random valid/pop/throttle traffic scored against the queue model.
        do_reset(1'b0, 8'd0);
        acc = 0;
        exp_und = 1'b0;
        prev_hs = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            check_output("rnd_empty", rd_empty, (q.size() == 0));
            check_output("rnd_underrun", err_underrun, exp_und);
            check_output("rnd_beats", beat_cnt, acc);
            if (cyc % 64 == 0) begin
                cfg_thr_en  = 1'($urandom_range(0, 1));
                cfg_thr_pct = 8'($urandom_range(0, 255));
            end
            if (!s_tvalid || prev_hs) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                new_beat();
            end
            rd_en = ($urandom_range(0, 2) == 0);
            if (rd_en && q.size() == 0) exp_und = 1'b1;
            if (rd_en && q.size() != 0) pop_compare("rnd");
            hs = s_tvalid && s_tready;
            if (hs) begin
                check_output("rnd_no_overflow", (q.size() < DEPTH), 1'b1);
                q.push_back(cur);
                acc++;
            end
            prev_hs = hs;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        rd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
